// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with its own sequencer and HI/LO registers.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise every op is unsigned.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               divzero_q, divzero_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   in_mag_a_s, in_mag_b_s;
  logic [WIDTH:0]     add_a_s, add_b_s;
  logic               sub_s;
  logic [WIDTH+1:0]   sum_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

`ifdef MULDIV_SIGNED_EN
  logic               sign_res_q, sign_res_d;
  logic               sign_rem_q, sign_rem_d;
  logic               signed_op_s;
  logic [2*WIDTH-1:0] prod_s;

  always_comb begin
    signed_op_s = ~op[0];
    in_mag_a_s  = (signed_op_s && a[WIDTH-1]) ? (~a + 1'b1) : a;
    in_mag_b_s  = (signed_op_s && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // Sign correction of the unsigned result, then the divide-by-zero override.
  always_comb begin
    prod_s = sign_res_q ? (~acc_q + 1'b1) : acc_q;
    if (is_div_q) begin
      fix_lo_s = sign_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      fix_hi_s = sign_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo_s = prod_s[WIDTH-1:0];
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
    if (divzero_q) begin
      fix_hi_s = raw_a_q;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      fix_hi_s = fix_hi_s;
      fix_lo_s = fix_lo_s;
    end
  end
`else
  logic unused_op0_s;
  assign unused_op0_s = op[0];

  always_comb begin
    in_mag_a_s = a;
    in_mag_b_s = b;
  end

  always_comb begin
    fix_hi_s = divzero_q ? raw_a_q : acc_q[2*WIDTH-1:WIDTH];
    fix_lo_s = divzero_q ? {WIDTH{1'b1}} : acc_q[WIDTH-1:0];
  end
`endif

  // Shared 33-bit adder: multiplicand add for MULT, trial subtract for DIV.
  always_comb begin
    if (is_div_q) begin
      add_a_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_b_s = {1'b0, mag_b_q};
      sub_s   = 1'b1;
    end else begin
      add_a_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b_s = acc_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}};
      sub_s   = 1'b0;
    end
    sum_s = {1'b0, add_a_s} + {1'b0, add_b_s ^ {(WIDTH+1){sub_s}}}
          + {{(WIDTH+1){1'b0}}, sub_s};
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    raw_a_d   = raw_a_q;
    divzero_d = divzero_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_SIGNED_EN
    sign_res_d = sign_res_q;
    sign_rem_d = sign_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PREP;
          is_div_d  = op[1];
          mag_a_d   = in_mag_a_s;
          mag_b_d   = in_mag_b_s;
          raw_a_d   = a;
          divzero_d = op[1] && (b == {WIDTH{1'b0}});
`ifdef MULDIV_SIGNED_EN
          sign_res_d = signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
          sign_rem_d = signed_op_s && a[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        // Low half of acc holds the multiplier or the dividend (future quotient).
        acc_d   = is_div_q ? {{WIDTH{1'b0}}, mag_a_q} : {{WIDTH{1'b0}}, mag_b_q};
        cnt_d   = {CW{1'b0}};
        state_d = S_RUN;
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = {(sum_s[WIDTH+1] ? sum_s[WIDTH-1:0] : add_a_s[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], sum_s[WIDTH+1]};
        end else begin
          acc_d = {sum_s[WIDTH:0], acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        hi_d    = fix_hi_s;
        lo_d    = fix_lo_s;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d     = (state_d == S_DONE);
    div_zero_d = (state_d == S_DONE) && divzero_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      mag_a_q    <= {WIDTH{1'b0}};
      mag_b_q    <= {WIDTH{1'b0}};
      raw_a_q    <= {WIDTH{1'b0}};
      divzero_q  <= 1'b0;
      acc_q      <= {(2*WIDTH){1'b0}};
      cnt_q      <= {CW{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      raw_a_q    <= raw_a_d;
      divzero_q  <= divzero_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      sign_res_q <= sign_res_d;
      sign_rem_q <= sign_rem_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expectations queued at start, checked on done.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
    int               done_edge;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: count edges, compare every done cycle against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          check_val("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("hi", 64'(hi), 64'(e.hi));
          check_val("lo", 64'(lo), 64'(e.lo));
          check_val("div_zero", 64'(div_zero), 64'(e.dz));
          check_val("done_latency", 64'(edge_cnt), 64'(e.done_edge));
        end
      end else if (div_zero) begin
        check_val("div_zero_outside_done", 64'(div_zero), 64'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el, input logic edz,
                       input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    if (push) begin
      e.hi        = eh;
      e.lo        = el;
      e.dz        = edz;
      e.done_edge = edge_cnt + WIDTH + 2;
      sb.push_back(e);
    end
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Returns in the done cycle; optionally pulses start there (must be ignored).
  task automatic wait_done(input bit pulse_in_done);
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check_val("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    if (pulse_in_done) begin
      start = 1'b1;
      op    = 2'b01;
      a     = 32'h0000_0009;
      b     = 32'h0000_0009;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] x, y;
    logic [63:0]      p;
    int               n_low;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_div_zero", 64'(div_zero), 64'd0);
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // MULTU max x max, with busy tracked from E0 through the FIX cycle.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    check_val("busy_after_start", 64'(busy), 64'd1);
    n_low = 0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      @(posedge clk);
      #1;
      if (!busy) n_low++;
    end
    check_val("busy_gap_cycles", 64'(n_low), 64'd0);
    wait_done(1'b0);
    check_val("busy_in_done", 64'(busy), 64'd0);
    check_val("done_in_done", 64'(done), 64'd1);

`ifdef MULDIV_SIGNED_EN
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_done(1'b0);
`else
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 1'b1);
    wait_done(1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
    wait_done(1'b0);
`endif

    // Divide by zero, then a normal divide with start pulses in RUN and DONE.
    issue(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done(1'b0);
    issue(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'h0000_0005;
    b     = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1);

    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 2 == 0) begin
        p = 64'(x) * 64'(y);
        issue(2'b01, x, y, p[63:32], p[31:0], 1'b0, 1'b1);
      end else begin
        y = y | 32'h0000_0001;
        issue(2'b11, x, y, x % y, x / y, 1'b0, 1'b1);
      end
      wait_done(1'b0);
    end

    // Abort a MULTU at RUN iteration 10; it must never signal done.
    issue(2'b01, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_hi", 64'(hi), 64'd0);
    check_val("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(posedge clk);
    issue(2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b1);
    wait_done(1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
